// File: rtl/framebuffer_writer.sv
// framebuffer_writer: sink end of the raster pixel stream.
// Clips each incoming pixel to the screen, packs it to RGB565, computes its
// linear word address, buffers it in a small FIFO and drains the FIFO to
// framebuffer memory with a request/acknowledge master.
//
// Memory handshake: o_mem_req is the valid and i_mem_ack is the ready.
// A write transfers on a rising edge where both are high. While o_mem_req=1
// and i_mem_ack=0, o_mem_addr/o_mem_data are held stable. i_mem_ack is
// ignored whenever o_mem_req=0.
//
// The pixel input has no backpressure. When the FIFO is full, the stage
// register keeps its pixel, and a newly arriving visible pixel is dropped
// and raises o_overflow. This gives a capacity of FIFO_DEPTH+2 pixels
// (output register, FIFO, stage register) while memory is stalled.
module framebuffer_writer #(
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240,
  parameter int FB_BASE    = 0,
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_write_pixel,
  input  logic signed [15:0]    i_x,
  input  logic signed [15:0]    i_y,
  input  logic [7:0]            i_r,
  input  logic [7:0]            i_g,
  input  logic [7:0]            i_b,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [15:0]           o_mem_data,
  input  logic                  i_mem_ack,
  input  logic                  i_clear_stats,
  output logic                  o_overflow,
  output logic [15:0]           o_clipped_count,
  output logic                  o_busy,
  output logic                  o_fsm_state
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Clip test and pixel packing (combinational, from the raw inputs)
  // ---------------------------------------------------------------------
  logic signed [31:0]    x_ext;
  logic signed [31:0]    y_ext;
  logic                  pix_clipped;
  logic                  pix_visible;
  logic                  pix_clip_event;
  logic [ADDR_WIDTH-1:0] pix_addr;
  logic [15:0]           pix_data;

  assign x_ext = {{16{i_x[15]}}, i_x};
  assign y_ext = {{16{i_y[15]}}, i_y};

  assign pix_clipped = (x_ext < 0) || (x_ext >= SCREEN_W) ||
                       (y_ext < 0) || (y_ext >= SCREEN_H);

  assign pix_visible    = i_write_pixel && !pix_clipped;
  assign pix_clip_event = i_write_pixel &&  pix_clipped;

  // Arithmetic modulo 2^ADDR_WIDTH gives the same low bits as computing in
  // 32 bits and truncating. Coordinates are non-negative whenever the
  // address is used, so zero extension is correct.
  assign pix_addr = ADDR_WIDTH'(FB_BASE)
                  + ADDR_WIDTH'($unsigned(i_y)) * ADDR_WIDTH'(SCREEN_W)
                  + ADDR_WIDTH'($unsigned(i_x));

  assign pix_data = {i_r[7:3], i_g[7:2], i_b[7:3]};

  // Low colour bits are intentionally discarded by the RGB565 packing.
  logic unused_colour_bits;
  assign unused_colour_bits = ^{i_r[2:0], i_g[1:0], i_b[2:0]};

  // ---------------------------------------------------------------------
  // Stage register and FIFO control
  // ---------------------------------------------------------------------
  logic                  stage_valid;
  logic [ADDR_WIDTH-1:0] stage_addr;
  logic [15:0]           stage_data;

  logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    fifo_head;

  logic                  stage_stall;
  logic                  push;
  logic                  pop;
  logic                  pixel_drop;

  state_t                state;

  // Full and empty are judged on occupancy before the edge.
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign fifo_head  = fifo_mem[rd_ptr];

  // The stage cannot hand off while the FIFO is full, so it holds its pixel;
  // a new visible pixel arriving then has nowhere to go and is dropped.
  assign stage_stall = stage_valid && fifo_full;
  assign push        = stage_valid && !fifo_full;
  assign pixel_drop  = pix_visible && stage_stall;

  // The FSM takes the head when idle, or when the current write is acked.
  assign pop = !fifo_empty &&
               ((state == S_IDLE) || ((state == S_REQ) && i_mem_ack));

  // Stage 1: latch visible pixels unless the stage is stalled on a full FIFO
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_valid <= 1'b0;
      stage_addr  <= '0;
      stage_data  <= '0;
    end else if (!stage_stall) begin
      stage_valid <= pix_visible;
      if (pix_visible) begin
        stage_addr <= pix_addr;
        stage_data <= pix_data;
      end
    end
  end

  // FIFO storage: written on push, contents are don't-care while empty
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {stage_addr, stage_data};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Memory write master
  // ---------------------------------------------------------------------

  // Memory FSM: issue the FIFO head, hold it until acked, chain back-to-back
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      o_mem_req  <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            {o_mem_addr, o_mem_data} <= fifo_head;
            o_mem_req                <= 1'b1;
            state                    <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_mem_ack) begin
            if (!fifo_empty) begin
              {o_mem_addr, o_mem_data} <= fifo_head;
            end else begin
              o_mem_req <= 1'b0;
              state     <= S_IDLE;
            end
          end
        end
        default: begin
          o_mem_req <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------

  // Sticky overflow flag; a drop on the same edge as a clear wins
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow <= 1'b0;
    end else if (pixel_drop) begin
      o_overflow <= 1'b1;
    end else if (i_clear_stats) begin
      o_overflow <= 1'b0;
    end
  end

  // Saturating clipped-pixel counter; a clip on the same edge as a clear counts as 1
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_clipped_count <= '0;
    end else if (pix_clip_event) begin
      if (i_clear_stats) begin
        o_clipped_count <= 16'd1;
      end else if (o_clipped_count != 16'hFFFF) begin
        o_clipped_count <= o_clipped_count + 16'd1;
      end
    end else if (i_clear_stats) begin
      o_clipped_count <= '0;
    end
  end

  assign o_busy      = stage_valid || !fifo_empty || o_mem_req;
  assign o_fsm_state = (state == S_REQ);

endmodule

// File: tb/tb_framebuffer_writer.sv
// Testbench for framebuffer_writer: directed scenarios plus a randomized
// run checked against a pixel-level reference model and expected queue.
module tb_framebuffer_writer;

  localparam int SW     = 320;
  localparam int SH     = 240;
  localparam int BASE   = 0;
  localparam int ADDR_W = 17;
  localparam int W      = ADDR_W + 16;

  logic                 i_clk;
  logic                 i_rst_n;
  logic                 i_write_pixel;
  logic signed [15:0]   i_x;
  logic signed [15:0]   i_y;
  logic [7:0]           i_r;
  logic [7:0]           i_g;
  logic [7:0]           i_b;
  logic                 o_mem_req;
  logic [ADDR_W-1:0]    o_mem_addr;
  logic [15:0]          o_mem_data;
  logic                 i_mem_ack;
  logic                 i_clear_stats;
  logic                 o_overflow;
  logic [15:0]          o_clipped_count;
  logic                 o_busy;
  logic                 o_fsm_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           exp_clipped;
  int           req_cycles;
  int           req_rises;
  logic         prev_req;

  framebuffer_writer #(
    .SCREEN_W  (SW),
    .SCREEN_H  (SH),
    .FB_BASE   (BASE),
    .ADDR_WIDTH(ADDR_W),
    .FIFO_DEPTH(8)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_write_pixel  (i_write_pixel),
    .i_x            (i_x),
    .i_y            (i_y),
    .i_r            (i_r),
    .i_g            (i_g),
    .i_b            (i_b),
    .o_mem_req      (o_mem_req),
    .o_mem_addr     (o_mem_addr),
    .o_mem_data     (o_mem_data),
    .i_mem_ack      (i_mem_ack),
    .i_clear_stats  (i_clear_stats),
    .o_overflow     (o_overflow),
    .o_clipped_count(o_clipped_count),
    .o_busy         (o_busy),
    .o_fsm_state    (o_fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Memory-side monitor: records completed writes and request activity
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_mem_req && i_mem_ack) got_q.push_back({o_mem_addr, o_mem_data});
      if (o_mem_req) req_cycles++;
      if (o_mem_req && !prev_req) req_rises++;
      prev_req = o_mem_req;
    end else begin
      prev_req = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_word(input int x, input int y,
                                              input int r, input int g, input int b);
    longint addr;
    int     data;
    addr = (longint'(BASE) + longint'(y) * SW + x) % (longint'(1) << ADDR_W);
    data = (r / 8) * 2048 + (g / 4) * 32 + (b / 8);
    return (W'(addr) << 16) | W'(data);
  endfunction

  task automatic model_pixel(input int x, input int y, input int r, input int g, input int b);
    if (x < 0 || x >= SW || y < 0 || y >= SH) exp_clipped++;
    else exp_q.push_back(model_word(x, y, r, g, b));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_pixel(input int x, input int y, input int r, input int g, input int b);
    i_write_pixel = 1'b1;
    i_x = 16'(x);
    i_y = 16'(y);
    i_r = 8'(r);
    i_g = 8'(g);
    i_b = 8'(b);
    model_pixel(x, y, r, g, b);
    tick();
    i_write_pixel = 1'b0;
  endtask

  task automatic pulse_clear();
    i_clear_stats = 1'b1;
    tick();
    i_clear_stats = 1'b0;
    exp_clipped = 0;
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    int n;
    n = 0;
    @(negedge i_clk);
    while (o_busy && n < max_cycles) begin
      @(negedge i_clk);
      n++;
    end
    ok = !o_busy;
  endtask

  task automatic reset_scoreboard();
    exp_q.delete();
    got_q.delete();
    exp_clipped = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst_n = 1'b0;
    i_write_pixel = 1'b0; i_x = '0; i_y = '0; i_r = '0; i_g = '0; i_b = '0;
    i_mem_ack = 1'b0; i_clear_stats = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    @(negedge i_clk);
    n_tests++;
    if ({o_mem_req, o_mem_addr, o_mem_data, o_overflow, o_clipped_count, o_busy, o_fsm_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: req=%0b addr=%0h data=%0h ovf=%0b clip=%0h busy=%0b st=%0b, required all zero",
               o_mem_req, o_mem_addr, o_mem_data, o_overflow, o_clipped_count, o_busy, o_fsm_state);
    end
  endtask

  task automatic test_single_pixel();
    int wait_cnt;
    logic [W-1:0] exp_w;
    reset_scoreboard();
    i_mem_ack = 1'b0;
    send_pixel(10, 20, 8'hFF, 8'h80, 8'h08);
    exp_w = {17'd6410, 16'hFC01};
    n_tests++;
    if (exp_q[0] !== exp_w) begin
      n_fail++;
      $display("FAIL single_model: got %0h, required %0h", exp_q[0], exp_w);
    end
    wait_cnt = 0;
    @(negedge i_clk);
    while (!o_mem_req && wait_cnt < 10) begin
      @(negedge i_clk);
      wait_cnt++;
    end
    n_tests++;
    if (wait_cnt !== 2) begin
      n_fail++;
      $display("FAIL single_latency: req after %0d extra edges, required 2", wait_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (o_mem_req !== 1'b1 || {o_mem_addr, o_mem_data} !== exp_w) begin
        n_fail++;
        $display("FAIL single_hold[%0d]: req=%0b word=%0h, required req=1 word=%0h",
                 i, o_mem_req, {o_mem_addr, o_mem_data}, exp_w);
      end
      @(negedge i_clk);
    end
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    @(negedge i_clk);
    n_tests++;
    if (o_mem_req !== 1'b0 || o_busy !== 1'b0 || o_fsm_state !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: req=%0b busy=%0b st=%0b, required 0 0 0", o_mem_req, o_busy, o_fsm_state);
    end
    n_tests++;
    if (got_q.size() !== 1 || got_q[0] !== exp_w) begin
      n_fail++;
      $display("FAIL single_write: %0d writes first=%0h, required 1 write %0h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_w);
    end
  endtask

  task automatic test_clipping();
    bit ok;
    reset_scoreboard();
    i_mem_ack = 1'b1;
    pulse_clear();
    send_pixel(-1, 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    send_pixel(320, 5, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    send_pixel(0, 240, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    send_pixel(319, 239, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    wait_idle(30, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL clip_timeout: busy=%0b, required 0", o_busy);
    end
    n_tests++;
    if (got_q.size() !== 1 || got_q[0][W-1:16] !== 17'd76799 || got_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL clip_write: %0d writes first=%0h, required 1 write %0h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
    end
    n_tests++;
    if (o_clipped_count !== 16'(exp_clipped) || exp_clipped != 3 || o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clip_stats: count=%0d ovf=%0b, required count=3 ovf=0", o_clipped_count, o_overflow);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    reset_scoreboard();
    i_mem_ack = 1'b0;
    pulse_clear();
    for (int i = 0; i < 11; i++) begin
      // The last pixel arrives together with a clear: the drop must win.
      if (i == 10) i_clear_stats = 1'b1;
      send_pixel(i, 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      i_clear_stats = 1'b0;
    end
    // Capacity with memory stalled is 10 pixels: the 11th is the one lost.
    void'(exp_q.pop_back());
    tick();
    @(negedge i_clk);
    n_tests++;
    if (o_overflow !== 1'b1 || o_mem_req !== 1'b1 || o_mem_addr !== 17'd0) begin
      n_fail++;
      $display("FAIL ovf_flag: ovf=%0b req=%0b addr=%0d, required ovf=1 req=1 addr=0",
               o_overflow, o_mem_req, o_mem_addr);
    end
    i_mem_ack = 1'b1;
    wait_idle(60, ok);
    n_tests++;
    if (!ok || got_q.size() !== 10) begin
      n_fail++;
      $display("FAIL ovf_count: %0d writes idle=%0b, required 10 writes idle=1", got_q.size(), ok);
    end
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i] || got_q[i][W-1:16] !== 17'(i)) begin
        n_fail++;
        $display("FAIL ovf_order[%0d]: got %0h, required %0h", i, got_q[i], exp_q[i]);
      end
    end
    pulse_clear();
    @(negedge i_clk);
    n_tests++;
    if (o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%0b, required 0", o_overflow);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    reset_scoreboard();
    i_mem_ack = 1'b1;
    req_cycles = 0;
    req_rises = 0;
    for (int i = 0; i < 4; i++)
      send_pixel(i, 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    wait_idle(30, ok);
    n_tests++;
    if (!ok || req_cycles !== 4 || req_rises !== 1) begin
      n_fail++;
      $display("FAIL b2b_req: high %0d cycles in %0d bursts idle=%0b, required 4 cycles in 1 burst",
               req_cycles, req_rises, ok);
    end
    n_tests++;
    if (got_q.size() !== 4) begin
      n_fail++;
      $display("FAIL b2b_count: %0d writes, required 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_word[%0d]: got %0h, required %0h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    reset_scoreboard();
    i_mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) send_pixel(40 + i, 7, $urandom_range(0, 255), 8'h11, 8'h22);
    repeat (3) tick();
    @(negedge i_clk);
    n_tests++;
    if (o_mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pending: req=%0b, required 1", o_mem_req);
    end
    #2 i_rst_n = 1'b0;
    #1;
    n_tests++;
    if (o_mem_req !== 1'b0 || o_busy !== 1'b0 || o_mem_addr !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: req=%0b busy=%0b addr=%0h, required 0 0 0", o_mem_req, o_busy, o_mem_addr);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_mem_ack = 1'b1;
    req_cycles = 0;
    got_q.delete();
    repeat (10) tick();
    n_tests++;
    if (got_q.size() !== 0 || req_cycles !== 0) begin
      n_fail++;
      $display("FAIL rstmid_lost: %0d writes %0d req cycles, required 0 and 0", got_q.size(), req_cycles);
    end
  endtask

  task automatic test_random();
    bit ok;
    bit hold_valid;
    logic [W-1:0] held;
    int x, y, r, g, b;
    reset_scoreboard();
    pulse_clear();
    hold_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      i_mem_ack = ($urandom_range(0, 3) != 0);
      i_write_pixel = ($urandom_range(0, 3) == 0);
      if (i_write_pixel) begin
        x = int'($urandom_range(0, 440)) - 60;
        y = int'($urandom_range(0, 340)) - 50;
        if ($urandom_range(0, 15) == 0) x = ($urandom_range(0, 1) != 0) ? -32768 : 32767;
        if ($urandom_range(0, 15) == 0) y = ($urandom_range(0, 1) != 0) ? -32768 : 32767;
        r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
        i_x = 16'(x); i_y = 16'(y); i_r = 8'(r); i_g = 8'(g); i_b = 8'(b);
        model_pixel(x, y, r, g, b);
      end
      @(negedge i_clk);
      if (hold_valid) begin
        n_tests++;
        if (o_mem_req !== 1'b1 || {o_mem_addr, o_mem_data} !== held) begin
          n_fail++;
          $display("FAIL rand_stable: req=%0b word=%0h, required req=1 word=%0h",
                   o_mem_req, {o_mem_addr, o_mem_data}, held);
        end
      end
      hold_valid = o_mem_req && !i_mem_ack;
      held = {o_mem_addr, o_mem_data};
      tick();
    end
    i_write_pixel = 1'b0;
    i_mem_ack = 1'b1;
    wait_idle(100, ok);
    n_tests++;
    if (!ok || got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: %0d writes idle=%0b, required %0d writes", got_q.size(), ok, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_word[%0d]: got %0h, required %0h", i, got_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (o_clipped_count !== 16'(exp_clipped) || o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_stats: count=%0d ovf=%0b, required count=%0d ovf=0",
               o_clipped_count, o_overflow, exp_clipped);
    end
  endtask

  task automatic test_saturate();
    int exp_sat;
    reset_scoreboard();
    i_mem_ack = 1'b1;
    pulse_clear();
    for (int i = 0; i < 65540; i++) begin
      case ($urandom_range(0, 3))
        0: begin i_x = 16'(-1 - int'($urandom_range(0, 500))); i_y = 16'($urandom_range(0, 239)); end
        1: begin i_x = 16'(320 + $urandom_range(0, 500));      i_y = 16'($urandom_range(0, 239)); end
        2: begin i_x = 16'($urandom_range(0, 319)); i_y = 16'(-1 - int'($urandom_range(0, 500))); end
        default: begin i_x = 16'($urandom_range(0, 319)); i_y = 16'(240 + $urandom_range(0, 500)); end
      endcase
      i_write_pixel = 1'b1;
      exp_clipped++;
      tick();
    end
    i_write_pixel = 1'b0;
    exp_sat = (exp_clipped > 65535) ? 65535 : exp_clipped;
    @(negedge i_clk);
    n_tests++;
    if (o_clipped_count !== 16'(exp_sat) || got_q.size() !== 0) begin
      n_fail++;
      $display("FAIL sat_hold: count=%0h writes=%0d, required %0h and 0", o_clipped_count, got_q.size(), exp_sat);
    end
    i_x = -16'sd5; i_y = 16'sd3;
    i_write_pixel = 1'b1;
    i_clear_stats = 1'b1;
    tick();
    i_write_pixel = 1'b0;
    i_clear_stats = 1'b0;
    @(negedge i_clk);
    n_tests++;
    if (o_clipped_count !== 16'd1) begin
      n_fail++;
      $display("FAIL sat_clear_clip: count=%0d, required 1", o_clipped_count);
    end
    pulse_clear();
    @(negedge i_clk);
    n_tests++;
    if (o_clipped_count !== 16'd0) begin
      n_fail++;
      $display("FAIL sat_clear: count=%0d, required 0", o_clipped_count);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    req_cycles = 0;
    req_rises = 0;
    prev_req = 1'b0;
    exp_clipped = 0;
    test_reset();
    test_single_pixel();
    test_clipping();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
